// File: rtl/generation_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | generation_sequencer: steps row computation into the back bank and      |
// | swaps ping-pong banks on frame boundaries. Optional macro               |
// | GENERATION_SEQUENCER_STEP_EN adds a single-step input. Rev 1.0          |
// +------------------------------------------------------------------------+
module generation_sequencer #(
  parameter int Y_SIZE    = 720,
  parameter int Y_WIDTH   = 10,
  parameter int GEN_WIDTH = 16,
  parameter int TIMEOUT   = 4096
) (
  input  logic                 out_stream_aclk,
  input  logic                 periph_reset,
  input  logic                 pause,
  input  logic                 frame_end,
  input  logic                 valid_set,
`ifdef GENERATION_SEQUENCER_STEP_EN
  input  logic                 step,
`endif
  output logic                 calc_flag,
  output logic [Y_WIDTH-1:0]   calc_row,
  output logic                 bank_sel,
  output logic [GEN_WIDTH-1:0] gen_count,
  output logic                 gen_done,
  output logic                 timeout_err
);

  localparam int                 WD_W     = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0]    WD_LAST  = WD_W'(TIMEOUT - 1);
  localparam logic [Y_WIDTH-1:0] ROW_LAST = Y_WIDTH'(Y_SIZE - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CALC      = 2'd1,
    SWAP_WAIT = 2'd2
  } state_t;

  state_t          state;
  logic [WD_W-1:0] watchdog;
  logic            start;

`ifdef GENERATION_SEQUENCER_STEP_EN
  logic armed;
  // An armed step launches one generation regardless of pause.
  assign start = frame_end & (~pause | armed);
`else
  assign start = frame_end & ~pause;
`endif

  assign calc_flag = (state == CALC);

  always_ff @(posedge out_stream_aclk or posedge periph_reset) begin
    if (periph_reset) begin
      state       <= IDLE;
      calc_row    <= '0;
      bank_sel    <= 1'b0;
      gen_count   <= '0;
      gen_done    <= 1'b0;
      timeout_err <= 1'b0;
      watchdog    <= '0;
`ifdef GENERATION_SEQUENCER_STEP_EN
      armed       <= 1'b0;
`endif
    end else begin
      gen_done <= 1'b0;
      case (state)
        IDLE: begin
`ifdef GENERATION_SEQUENCER_STEP_EN
          if (step && pause && !armed) begin
            armed <= 1'b1;
          end
`endif
          if (start) begin
            state    <= CALC;
            calc_row <= '0;
            watchdog <= '0;
`ifdef GENERATION_SEQUENCER_STEP_EN
            armed    <= 1'b0;
`endif
          end
        end
        CALC: begin
          // valid_set wins over a coincident watchdog expiry.
          if (valid_set) begin
            watchdog <= '0;
            if (calc_row == ROW_LAST) begin
              calc_row <= '0;
              state    <= SWAP_WAIT;
            end else begin
              calc_row <= calc_row + 1'b1;
            end
          end else if (watchdog == WD_LAST) begin
            timeout_err <= 1'b1;
            calc_row    <= '0;
            watchdog    <= '0;
            state       <= IDLE;
          end else begin
            watchdog <= watchdog + 1'b1;
          end
        end
        SWAP_WAIT: begin
          if (frame_end) begin
            bank_sel  <= ~bank_sel;
            gen_count <= gen_count + 1'b1;
            gen_done  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/generation_sequencer.md
GENERATION_SEQUENCER -- requirements
Module: generation_sequencer

Interface
REQ-001 SHALL have parameter Y_SIZE, default 720, meaning number of grid rows per generation.
REQ-002 SHALL have parameter Y_WIDTH, default 10, meaning width of row index; Y_WIDTH SHALL equal $clog2(Y_SIZE).
REQ-003 SHALL have parameter GEN_WIDTH, default 16, meaning width of generation counter.
REQ-004 SHALL have parameter TIMEOUT, default 4096, meaning max cycles per row awaiting valid_set.
REQ-005 SHALL have port out_stream_aclk  in  1  single clock; all logic on rising edge.
REQ-006 SHALL have port periph_reset  in  1  asynchronous, active-high reset.
REQ-007 SHALL have port pause  in  1  pause flag from the AXI-Lite register file; 1 = hold current generation.
REQ-008 SHALL have port frame_end  in  1  one-cycle pulse from the output stage on the last pixel of a frame (lastx & lasty & ready).
REQ-009 SHALL have port valid_set  in  1  one-cycle pulse from line_buffer: current row result is written.
REQ-010 SHALL have port calc_flag  out  1  to line_buffer calc_flag_in; high while rows are being computed.
REQ-011 SHALL have port calc_row  out  Y_WIDTH  to line_buffer calc_row; row currently requested.
REQ-012 SHALL have port bank_sel  out  1  ping-pong select: 0 = display BRAM A / compute into B, 1 = the reverse.
REQ-013 SHALL have port gen_count  out  GEN_WIDTH  completed-generation count.
REQ-014 SHALL have port gen_done  out  1  one-cycle pulse when bank_sel toggles.
REQ-015 SHALL have port timeout_err  out  1  sticky flag: a row exceeded TIMEOUT.

Function
REQ-016 SHALL implement FSM with states IDLE, CALC, SWAP_WAIT.
REQ-017 In IDLE, SHALL move to CALC on the first cycle with pause=0 and frame_end=1; otherwise it SHALL stay in IDLE.
REQ-018 In CALC, SHALL drive calc_flag=1 combinationally from the state; IDLE and SWAP_WAIT SHALL drive 0.
REQ-019 calc_row SHALL be 0 on entry to CALC.
REQ-020 calc_row SHALL increment by 1 on each valid_set while calc_row < Y_SIZE-1.
REQ-021 On valid_set with calc_row = Y_SIZE-1, SHALL clear calc_row to 0 and go to SWAP_WAIT.
REQ-022 valid_set outside CALC SHALL be ignored.
REQ-023 pause SHALL be sampled only in IDLE; once a generation starts it SHALL run to completion.
REQ-024 In SWAP_WAIT, on frame_end SHALL toggle bank_sel, increment gen_count (wrapping 2^GEN_WIDTH-1 -> 0), pulse gen_done for exactly that cycle, and return to IDLE.
REQ-025 A frame_end in the same cycle as the final valid_set SHALL NOT complete the swap; the next frame_end SHALL.
REQ-026 bank_sel SHALL change only on frame boundaries, so the display never tears mid-frame.
REQ-027 SHALL keep a row watchdog counter, cleared on entry to CALC and on every valid_set, incremented each CALC cycle.
REQ-028 When the watchdog reaches TIMEOUT-1 in CALC without valid_set, SHALL set timeout_err=1, clear calc_row to 0, and go to IDLE; bank_sel and gen_count SHALL be unchanged.
REQ-029 If valid_set and watchdog expiry coincide, valid_set SHALL take priority and no error SHALL be raised.
REQ-030 timeout_err SHALL clear only on reset.
REQ-031 All outputs SHALL be registered except calc_flag (REQ-018).

Reset
REQ-032 Asserting periph_reset SHALL immediately force: state IDLE, calc_row=0, bank_sel=0, gen_count=0, gen_done=0, timeout_err=0, watchdog=0.
REQ-033 Reset mid-CALC SHALL abandon the generation with no bank swap, and the block SHALL restart from row 0 after release.

Configuration
REQ-034 The macro GENERATION_SEQUENCER_STEP_EN SHALL add input port step (1 bit): while pause=1, a step pulse in IDLE SHALL arm one generation, which then starts on the next frame_end per REQ-017, ignoring pause.
REQ-035 With GENERATION_SEQUENCER_STEP_EN defined, a step pulse while already armed or outside IDLE SHALL be ignored.
REQ-036 Without GENERATION_SEQUENCER_STEP_EN, the step port SHALL be absent and pause=1 SHALL block all generations.

Verification
REQ-037 Reset, pause=0, frame_end pulse, then 720 valid_set pulses spaced 5 cycles -> calc_row 0..719 in order, calc_flag high throughout, FSM in SWAP_WAIT; then frame_end -> bank_sel=1, gen_count=1, gen_done pulse of 1 cycle.
REQ-038 pause=1 with repeated frame_end -> calc_flag stays 0 and gen_count stays 0; raise pause at row 300 of a running generation -> calc_row still reaches 719 and bank swaps.
REQ-039 Final valid_set coincident with frame_end -> no swap that cycle; swap on the next frame_end.
REQ-040 In CALC, withhold valid_set for 4096 cycles -> timeout_err=1, calc_row=0, state IDLE, bank_sel unchanged; valid_set at cycle 4095 instead -> no error.
REQ-041 Assert periph_reset at row 400 -> all outputs at reset values on the same edge; after release and frame_end -> calc_row restarts at 0.
REQ-042 With GENERATION_SEQUENCER_STEP_EN: pause=1, step pulse, frame_end -> exactly one generation runs, gen_count=1, then block stays in IDLE.
